// File: rtl/store_buffer_drain.sv
// Post-commit store buffer: drains committed stores to the data cache in order,
// one at a time, and answers a combinational store-to-load forwarding lookup.
module store_buffer_drain #(
  parameter int unsigned SB_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_valid,
  input  logic [31:0]               enq_addr,
  input  logic [31:0]               enq_data,
  input  logic [3:0]                enq_mask,
  output logic                      enq_ready,
  output logic [31:0]               dmem_addr,
  output logic [3:0]                dmem_wmask,
  output logic [31:0]               dmem_wdata,
  input  logic                      dmem_resp,
  input  logic [31:0]               ld_addr,
  input  logic [3:0]                ld_rmask,
  output logic                      fwd_hit,
  output logic [31:0]               fwd_data,
  output logic                      fwd_stall,
  output logic [$clog2(SB_DEPTH):0] count,
  output logic                      empty
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_IDLE, S_WAIT_RESP} state_t;

  logic [31:2]   r_addr  [SB_DEPTH];
  logic [31:0]   r_data  [SB_DEPTH];
  logic [3:0]    r_mask  [SB_DEPTH];
  logic          r_sent  [SB_DEPTH];
  logic          r_valid [SB_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_dmem_addr;
  logic [3:0]    r_dmem_wmask;
  logic [31:0]   r_dmem_wdata;

  logic          w_enq;
  logic          w_issue;
  logic          w_pop;
  logic          w_fwd_hit;
  logic          w_fwd_stall;
  logic [31:0]   w_fwd_data;
  logic          w_found;
  logic [PW-1:0] w_idx;
  logic          w_unused_addr_lsbs;

  // Byte offset within the word is carried by the masks, not the address.
  assign w_unused_addr_lsbs = ^{enq_addr[1:0], ld_addr[1:0]};

  assign enq_ready  = (r_count != CW'(SB_DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign w_enq      = enq_valid && enq_ready;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wmask = r_dmem_wmask;
  assign dmem_wdata = r_dmem_wdata;
  assign fwd_hit    = w_fwd_hit;
  assign fwd_stall  = w_fwd_stall;
  assign fwd_data   = w_fwd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !r_sent[r_head]) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (dmem_resp) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_mask[i]  <= '0;
        r_sent[i]  <= 1'b0;
        r_valid[i] <= 1'b0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wmask <= '0;
      r_dmem_wdata <= '0;
    end else begin
      if (w_enq) begin
        r_addr[r_tail]  <= enq_addr[31:2];
        r_data[r_tail]  <= enq_data;
        r_mask[r_tail]  <= enq_mask;
        r_sent[r_tail]  <= 1'b0;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_issue) begin
        r_sent[r_head] <= 1'b1;
        r_dmem_addr    <= {r_addr[r_head], 2'b00};
        r_dmem_wmask   <= r_mask[r_head];
        r_dmem_wdata   <= r_data[r_head];
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
        r_dmem_addr     <= '0;
        r_dmem_wmask    <= '0;
        r_dmem_wdata    <= '0;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk from youngest (tail-1) to oldest; offset SB_DEPTH wraps onto tail,
  // which is the head when the buffer is full.
  always_comb begin
    w_fwd_hit   = 1'b0;
    w_fwd_stall = 1'b0;
    w_fwd_data  = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    if (ld_rmask != '0) begin
      for (int unsigned i = 1; i <= SB_DEPTH; i++) begin
        w_idx = r_tail - PW'(i);
        if (!w_found && r_valid[w_idx] && (r_addr[w_idx] == ld_addr[31:2]) &&
            ((r_mask[w_idx] & ld_rmask) != '0)) begin
          w_found = 1'b1;
          if ((ld_rmask & ~r_mask[w_idx]) == '0) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[w_idx];
          end else begin
            w_fwd_stall = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_drain.sv
// Bench for store_buffer_drain: directed test-plan steps plus a randomized phase,
// all checked against a queue-based reference model of the buffer.
module tb_store_buffer_drain;

  localparam int unsigned SB_DEPTH = 8;
  localparam int unsigned CW       = $clog2(SB_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enq_valid = 1'b0;
  logic [31:0]   enq_addr  = '0;
  logic [31:0]   enq_data  = '0;
  logic [3:0]    enq_mask  = '0;
  logic          enq_ready;
  logic [31:0]   dmem_addr;
  logic [3:0]    dmem_wmask;
  logic [31:0]   dmem_wdata;
  logic          dmem_resp = 1'b0;
  logic [31:0]   ld_addr   = '0;
  logic [3:0]    ld_rmask  = '0;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          fwd_stall;
  logic [CW-1:0] count;
  logic          empty;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer_drain #(.SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data),
    .enq_mask(enq_mask), .enq_ready(enq_ready),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp),
    .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .count(count), .empty(empty)
  );

  // Reference model: program-ordered queue of buffered stores plus the request in flight.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy   = 1'b0;
  logic [31:0] m_daddr  = '0;
  logic [31:0] m_dwdata = '0;
  logic [3:0]  m_dmask  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy   = 1'b0;
    m_daddr  = '0;
    m_dwdata = '0;
    m_dmask  = '0;
  endtask

  task automatic tick();
    bit   full, pop, issue, enq;
    ent_t e;
    full  = (mq.size() == SB_DEPTH);
    pop   = m_busy && dmem_resp;
    issue = !m_busy && (mq.size() != 0);
    enq   = enq_valid && !full;
    e.a   = enq_addr;
    e.d   = enq_data;
    e.m   = enq_mask;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_busy   = 1'b0;
        m_daddr  = '0;
        m_dwdata = '0;
        m_dmask  = '0;
      end
      if (issue) begin
        m_busy   = 1'b1;
        m_daddr  = {mq[0].a[31:2], 2'b00};
        m_dwdata = mq[0].d;
        m_dmask  = mq[0].m;
      end
      if (enq) mq.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    logic        e_hit, e_stall;
    logic [31:0] e_data;
    e_hit   = 1'b0;
    e_stall = 1'b0;
    e_data  = '0;
    if (ld_rmask != 4'h0) begin
      for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
        if (mq[i].a[31:2] == ld_addr[31:2] && (mq[i].m & ld_rmask) != 4'h0) begin
          if ((ld_rmask & ~mq[i].m) == 4'h0) begin
            e_hit  = 1'b1;
            e_data = mq[i].d;
          end else begin
            e_stall = 1'b1;
          end
          break;
        end
      end
    end
    chk($sformatf("%s.count", tag),     32'(count),      32'(mq.size()));
    chk($sformatf("%s.empty", tag),     32'(empty),      32'(mq.size() == 0));
    chk($sformatf("%s.enq_ready", tag), 32'(enq_ready),  32'(mq.size() != SB_DEPTH));
    chk($sformatf("%s.dmem_addr", tag), dmem_addr,       m_daddr);
    chk($sformatf("%s.dmem_wmask", tag), 32'(dmem_wmask), 32'(m_dmask));
    chk($sformatf("%s.dmem_wdata", tag), dmem_wdata,     m_dwdata);
    chk($sformatf("%s.fwd_hit", tag),   32'(fwd_hit),    32'(e_hit));
    chk($sformatf("%s.fwd_stall", tag), 32'(fwd_stall),  32'(e_stall));
    chk($sformatf("%s.fwd_data", tag),  fwd_data,        e_data);
  endtask

  task automatic drain(input string tag);
    int unsigned budget;
    budget    = 0;
    dmem_resp = 1'b1;
    while (mq.size() != 0 && budget < 100) begin
      tick();
      #1;
      check_all(tag);
      budget++;
    end
    chk($sformatf("%s.drained", tag), 32'(count), 32'(0));
    dmem_resp = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values, applied asynchronously
    #1 rst = 1'b1;
    #1;
    check_all("reset");
    chk("reset.wmask_zero", 32'(dmem_wmask), 32'(0));
    chk("reset.enq_ready",  32'(enq_ready),  32'(1));
    tick();
    tick();
    rst = 1'b0;

    // Single store, response three cycles after the request
    enq_valid = 1'b1; enq_addr = 32'h1000_0004; enq_data = 32'hDEAD_BEEF; enq_mask = 4'hF;
    tick();
    enq_valid = 1'b0;
    #1;
    check_all("single.enq");
    chk("single.count1", 32'(count), 32'(1));
    for (int c = 0; c < 3; c++) begin
      if (c == 2) dmem_resp = 1'b1;
      tick();
      if (c == 0) begin
        #1;
        check_all("single.req");
      end
      if (c != 2) begin
        chk("single.addr",  dmem_addr,        32'h1000_0004);
        chk("single.wmask", 32'(dmem_wmask),  32'hF);
        chk("single.wdata", dmem_wdata,       32'hDEAD_BEEF);
      end
    end
    dmem_resp = 1'b0;
    chk("single.count0", 32'(count), 32'(0));
    chk("single.empty",  32'(empty), 32'(1));
    chk("single.wmask0", 32'(dmem_wmask), 32'(0));

    // Fill with no responses; a ninth store is ignored
    for (int k = 0; k < 9; k++) begin
      enq_valid = 1'b1;
      enq_addr  = 32'h4000_0000 + 32'(4 * k);
      enq_data  = $urandom;
      enq_mask  = 4'hF;
      tick();
      #1;
      check_all("fill");
    end
    enq_valid = 1'b0;
    chk("fill.count8",    32'(count),     32'(8));
    chk("fill.not_ready", 32'(enq_ready), 32'(0));

    // One response while full, then refill through the wrap and drain in order
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    #1;
    check_all("pop1");
    chk("pop1.count7", 32'(count),     32'(7));
    chk("pop1.ready",  32'(enq_ready), 32'(1));
    enq_valid = 1'b1; enq_addr = 32'h4000_0100; enq_data = 32'hCAFE_F00D; enq_mask = 4'h5;
    tick();
    enq_valid = 1'b0;
    #1;
    check_all("wrap");
    chk("wrap.count8", 32'(count), 32'(8));
    drain("wrap.drain");

    // Forwarding: partial cover, disjoint lanes, then youngest full-word store wins
    enq_valid = 1'b1; enq_addr = 32'h2000_0001; enq_data = 32'h0000_AB00; enq_mask = 4'h2;
    tick();
    enq_valid = 1'b0;
    ld_addr = 32'h2000_0000; ld_rmask = 4'h3;
    #1;
    check_all("fwd.partial");
    chk("fwd.partial.stall", 32'(fwd_stall), 32'(1));
    chk("fwd.partial.hit",   32'(fwd_hit),   32'(0));
    ld_rmask = 4'h4;
    #1;
    check_all("fwd.disjoint");
    chk("fwd.disjoint.both", 32'({fwd_hit, fwd_stall}), 32'(0));
    enq_valid = 1'b1; enq_addr = 32'h2000_0000; enq_data = 32'h1122_3344; enq_mask = 4'hF;
    ld_rmask  = 4'h2;
    #1;
    check_all("fwd.same_cycle");
    tick();
    enq_valid = 1'b0;
    #1;
    check_all("fwd.youngest");
    chk("fwd.youngest.hit",  32'(fwd_hit), 32'(1));
    chk("fwd.youngest.data", fwd_data,     32'h1122_3344);
    ld_rmask = 4'h0;
    drain("fwd.drain");

    // Reset during an outstanding request with three stores buffered
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1'b1;
      enq_addr  = 32'h5000_0000 + 32'(4 * k);
      enq_data  = $urandom;
      enq_mask  = 4'hF;
      tick();
    end
    enq_valid = 1'b0;
    #1;
    check_all("rstmid.pre");
    chk("rstmid.busy", 32'(dmem_wmask != 4'h0), 32'(1));
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rstmid.wmask", 32'(dmem_wmask), 32'(0));
    chk("rstmid.count", 32'(count),      32'(0));
    chk("rstmid.ready", 32'(enq_ready),  32'(1));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      check_all("rstmid.after");
      chk("rstmid.no_req", 32'(dmem_wmask), 32'(0));
    end

    // Randomized traffic on a few aliasing words
    for (int c = 0; c < 400; c++) begin
      enq_valid = 1'($urandom_range(0, 1));
      enq_addr  = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      enq_data  = $urandom;
      enq_mask  = 4'($urandom_range(1, 15));
      dmem_resp = ($urandom_range(0, 2) == 0);
      ld_addr   = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      ld_rmask  = 4'($urandom_range(0, 15));
      #1;
      check_all("rand");
      tick();
    end
    enq_valid = 1'b0;
    ld_rmask  = 4'h0;
    drain("rand.drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
